stage_sequencer: RTL and testbench
==================================

# stage_sequencer

Multi-cycle stage sequencer that generates the 3-bit `stage` code consumed by `main_control`. Together with the opcode, this code selects every datapath control signal. The block walks each instruction through fetch, decode, execute, memory and write-back, skips the stages the opcode class does not use, and holds on memory stalls. It sits beside `main_control` in the processor top level, driven by the instruction-register opcode.

## Interface
- No parameters; widths are fixed by the ISA.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `run` in 1: permits starting a new instruction from idle or after retirement.
- `stall` in 1: memory busy; freezes the current stage.
- `op` in 6: opcode from the instruction register; valid from stage 2 onward.
- `stage` out 3: 000 idle, 001 fetch, 010 decode, 011 execute, 100 memory, 101 write-back.
- `irWrite` out 1: instruction-register load enable.
- `instr_done` out 1: one-cycle pulse in the final stage cycle of an instruction.
- `illegal_op` out 1: one-cycle pulse when decode sees an undefined opcode.
- `instr_count` out 16: retired-instruction count; present only with `STAGE_SEQ_PERF_EN`.

## Operation
Opcode classes and their stage paths:
- ALU: 000000–000101 → 001, 010, 011, 101.
- LW: 000110 → 001, 010, 011, 100, 101.
- SW: 000111 → 001, 010, 011, 100.
- Branch: 001000–001011 → 001, 010, 011.
- Jump/call/ret: 001100–001110 → 001, 010.
- PUSH: 001111 → 001, 010, 100, 101.
- POP: 010000 → 001, 010, 100, 101.
- All other opcodes: illegal.

State and control rules:
- The state register holds `stage` plus a latched class register. The class is captured from `op` on the decode cycle (stage 010, `stall`=0). Later `op` changes do not alter the path.
- Next-state logic:
  - idle → fetch if `run`=1.
  - In the last stage of the class path: → fetch if `run`=1, else → idle.
  - Otherwise → the next stage on the class path.
- `stall`=1 holds `stage` and the class register and suppresses all pulses. It is honoured in every stage except idle.
- Illegal opcode in decode: `illegal_op`=1 for that cycle, then behaves as the last stage (→ fetch or idle). `instr_done` stays 0.
- `run` deasserted mid-instruction does not abort it; the instruction completes and then the block enters idle.
- Stage codes 110 and 111 are unreachable. If ever present, the next state is idle.

## Timing
- Reset (`rst_n`=0 at an edge): `stage`=000, class register cleared, `irWrite`=0, `instr_done`=0, `illegal_op`=0, `instr_count`=0. This applies mid-instruction too: the next edge forces idle regardless of `stall`.
- `irWrite` = (`stage`==001) && !`stall`, decoded combinationally from registered state.
- `instr_done` = last-stage && !`stall` && legal.
- `illegal_op` = (`stage`==010) && !`stall` && undefined op.
- Latency from `run`=1 in idle: fetch on the next edge. Instruction length is 2–5 cycles plus stall cycles.
- Back-to-back instructions: the last stage is followed directly by 001, with no idle bubble.
- `op` must be stable during the decode cycle. It is sampled on the edge that ends decode and is also used combinationally for `illegal_op`.

## Configuration
- `STAGE_SEQ_PERF_EN` defined: `instr_count` port exists.
  - Increments by 1 on every `instr_done` pulse.
  - Wraps from FFFF to 0000.
  - Cleared by reset.
- `STAGE_SEQ_PERF_EN` undefined: the port and the counter are absent; all other behaviour is identical.

## Structure
- Shared package `stage_pkg`:
  - stage encodings (IDLE, FETCH, DECODE, EXEC, MEM, WB);
  - opcode constants (ADD 000001, LW 000110, SW 000111, BEQ 001010, PUSH 001111, POP 010000);
  - opcode-class enum.
- `main_control` imports the same stage constants.
- One sub-module, `op_class_decode`: combinational, maps `op` to class, illegal flag and a per-class next-stage function.

## Test plan
- Reset, then `run`=1 with `op`=000001 (ADD): `stage` = 001, 010, 011, 101; `instr_done`=1 in the 101 cycle only; then 001.
- `op`=000110 (LW) with `stall`=1 for 2 cycles in stage 100: `stage` holds 100 for 3 cycles, then 101; `instr_done` fires once.
- `op`=001010 (BEQ) then `op`=001111 (PUSH), `run`=1: the sequence is 001, 010, 011, 001, 010, 100, 101, with no idle between.
- `op`=111111: `illegal_op`=1 in the decode cycle, `instr_done` never fires, next `stage`=001.
- `run`=0 asserted during stage 011 of SW (000111): stages 100, then 000, then `stage` stays 000.
- `rst_n`=0 for one edge while in stage 100 with `stall`=1: `stage`=000 next cycle; with `STAGE_SEQ_PERF_EN`, `instr_count`=0, and it reads 3 after three completed ADDs.

Source files
------------

// File: rtl/stage_pkg.sv
// Stage encodings, opcode constants, opcode classes and the per-class stage-path
// helper. The path helper is shared by the sequencer and main_control.
package stage_pkg;

   localparam logic [2:0] STG_IDLE   = 3'b000;
   localparam logic [2:0] STG_FETCH  = 3'b001;
   localparam logic [2:0] STG_DECODE = 3'b010;
   localparam logic [2:0] STG_EXEC   = 3'b011;
   localparam logic [2:0] STG_MEM    = 3'b100;
   localparam logic [2:0] STG_WB     = 3'b101;

   localparam logic [5:0] OP_ADD  = 6'b000001;
   localparam logic [5:0] OP_LW   = 6'b000110;
   localparam logic [5:0] OP_SW   = 6'b000111;
   localparam logic [5:0] OP_BEQ  = 6'b001010;
   localparam logic [5:0] OP_PUSH = 6'b001111;
   localparam logic [5:0] OP_POP  = 6'b010000;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_ALU  = 3'd1,
      CLS_LW   = 3'd2,
      CLS_SW   = 3'd3,
      CLS_BR   = 3'd4,
      CLS_JMP  = 3'd5,
      CLS_PUSH = 3'd6,
      CLS_POP  = 3'd7
   } opClass_t;

   typedef struct packed {
      logic       last;
      logic [2:0] nxt;
   } pathStep_t;

   // CLS_NONE ends at decode so an illegal opcode retires there.
   // Idle and the unused codes never report last; the caller handles them.
   function automatic pathStep_t pathNext(input opClass_t cls, input logic [2:0] stg);
      pathStep_t res;
      res.last = 1'b0;
      res.nxt  = STG_IDLE;
      case (stg)
         STG_FETCH: res.nxt = STG_DECODE;
         STG_DECODE: begin
            case (cls)
               CLS_ALU, CLS_LW, CLS_SW, CLS_BR: res.nxt = STG_EXEC;
               CLS_PUSH, CLS_POP:               res.nxt = STG_MEM;
               default:                         res.last = 1'b1;
            endcase
         end
         STG_EXEC: begin
            case (cls)
               CLS_ALU:         res.nxt = STG_WB;
               CLS_LW, CLS_SW:  res.nxt = STG_MEM;
               default:         res.last = 1'b1;
            endcase
         end
         STG_MEM: begin
            case (cls)
               CLS_LW, CLS_PUSH, CLS_POP: res.nxt = STG_WB;
               default:                   res.last = 1'b1;
            endcase
         end
         STG_WB:  res.last = 1'b1;
         default: res.last = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Sequencer control bus; instr_count exists only when STAGE_SEQ_PERF_EN is defined.
// master = processor top driving run/stall/op, slave = the sequencer.
interface stage_sequencer_if;
   logic       run;
   logic       stall;
   logic [5:0] op;
   logic [2:0] stage;
   logic       irWrite;
   logic       instr_done;
   logic       illegal_op;
`ifdef STAGE_SEQ_PERF_EN
   logic [15:0] instr_count;

   modport master (output run, stall, op,
                   input  stage, irWrite, instr_done, illegal_op, instr_count);
   modport slave  (input  run, stall, op,
                   output stage, irWrite, instr_done, illegal_op, instr_count);
`else
   modport master (output run, stall, op,
                   input  stage, irWrite, instr_done, illegal_op);
   modport slave  (input  run, stall, op,
                   output stage, irWrite, instr_done, illegal_op);
`endif
endinterface

// File: rtl/stage_sequencer_op_class_decode.sv
// Combinational opcode classifier and next-stage lookup; zero latency, no state.
// In decode the live opcode picks the path, elsewhere the latched class does.
module op_class_decode
   import stage_pkg::*;
(
   input  logic [5:0] op,
   input  logic [2:0] stage,
   input  opClass_t   clsLatched,
   output opClass_t   opCls,
   output logic       illegal,
   output logic [2:0] nxtStage,
   output logic       lastStage,
   output logic       pathLegal
);

   opClass_t  effCls;
   pathStep_t stepRes;

   always_comb begin
      opCls = CLS_NONE;
      if (op inside {[6'd0:6'd5]})        opCls = CLS_ALU;
      else if (op == OP_LW)               opCls = CLS_LW;
      else if (op == OP_SW)               opCls = CLS_SW;
      else if (op inside {[6'd8:6'd11]})  opCls = CLS_BR;
      else if (op inside {[6'd12:6'd14]}) opCls = CLS_JMP;
      else if (op == OP_PUSH)             opCls = CLS_PUSH;
      else if (op == OP_POP)              opCls = CLS_POP;
   end

   assign illegal   = (opCls == CLS_NONE);
   assign effCls    = (stage == STG_DECODE) ? opCls : clsLatched;
   assign stepRes   = pathNext(effCls, stage);
   assign nxtStage  = stepRes.nxt;
   assign lastStage = stepRes.last;
   assign pathLegal = (effCls != CLS_NONE);

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: fetch one edge after run in idle, 2-5 cycles per instruction.
// stall freezes stage/class and masks pulses; STAGE_SEQ_PERF_EN adds instr_count.
module stage_sequencer
   import stage_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   stage_sequencer_if.slave   bus
);

   logic [2:0] stageQ;
   opClass_t   clsQ;
   opClass_t   opCls;
   logic       illegal;
   logic [2:0] nxtStage;
   logic       lastStage;
   logic       pathLegal;
   logic       advance;
   logic       doneHit;

   op_class_decode u_decode (
      .op         (bus.op),
      .stage      (stageQ),
      .clsLatched (clsQ),
      .opCls      (opCls),
      .illegal    (illegal),
      .nxtStage   (nxtStage),
      .lastStage  (lastStage),
      .pathLegal  (pathLegal)
   );

   assign advance = !bus.stall;
   assign doneHit = lastStage && advance && pathLegal;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stageQ <= STG_IDLE;
         clsQ   <= CLS_NONE;
      end else if (stageQ == STG_IDLE) begin
         if (bus.run) stageQ <= STG_FETCH;
      end else if (stageQ > STG_WB) begin
         // unused codes recover to idle without waiting on stall
         stageQ <= STG_IDLE;
      end else if (advance) begin
         if (stageQ == STG_DECODE) clsQ <= opCls;
         if (lastStage) stageQ <= bus.run ? STG_FETCH : STG_IDLE;
         else           stageQ <= nxtStage;
      end
   end

   assign bus.stage      = stageQ;
   assign bus.irWrite    = (stageQ == STG_FETCH) && advance;
   assign bus.instr_done = doneHit;
   assign bus.illegal_op = (stageQ == STG_DECODE) && advance && illegal;

`ifdef STAGE_SEQ_PERF_EN
   logic [15:0] instrCountQ;

   always_ff @(posedge clk) begin
      if (!rst_n)       instrCountQ <= '0;
      else if (doneHit) instrCountQ <= instrCountQ + 16'd1;
   end

   assign bus.instr_count = instrCountQ;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench for stage_sequencer: per-cycle expectations queued at drive
// time and compared at the falling edge; instr_count checked when STAGE_SEQ_PERF_EN.
module tb_stage_sequencer;

   typedef struct packed {
      logic [2:0] stg;
      logic       ir;
      logic       done;
      logic       ill;
   } expRec_t;

   logic clk;
   logic rst_n;
   int   checkCnt;
   int   failCnt;

   expRec_t expQ[$];
   expRec_t curExp;

   stage_sequencer_if busIf ();

   stage_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (busIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checkCnt++;
      if (obs !== exp) begin
         failCnt++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive inputs, queue what the DUT must show this cycle, advance.
   task automatic step(input logic rn, input logic r, input logic s, input logic [5:0] o,
                       input logic [2:0] expStg, input logic expDone, input logic expIll);
      expRec_t e;
      rst_n      = rn;
      busIf.run  = r;
      busIf.stall = s;
      busIf.op   = o;
      e.stg  = expStg;
      e.ir   = (expStg == 3'b001) && !s;
      e.done = expDone;
      e.ill  = expIll;
      expQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (expQ.size() != 0) begin
         curExp = expQ.pop_front();
         checkEq("stage",      16'(busIf.stage),      16'(curExp.stg));
         checkEq("irWrite",    16'(busIf.irWrite),    16'(curExp.ir));
         checkEq("instr_done", 16'(busIf.instr_done), 16'(curExp.done));
         checkEq("illegal_op", 16'(busIf.illegal_op), 16'(curExp.ill));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1);
   end

   initial begin
      checkCnt = 0;
      failCnt  = 0;
      rst_n       = 1'b0;
      busIf.run   = 1'b0;
      busIf.stall = 1'b0;
      busIf.op    = 6'd0;
      repeat (2) @(posedge clk);
      #1;
      step(1'b0, 1'b0, 1'b0, 6'd0, 3'b000, 1'b0, 1'b0);
`ifdef STAGE_SEQ_PERF_EN
      checkEq("count_reset", busIf.instr_count, 16'd0);
`endif

      // ADD: 001 010 011 101, straight into LW
      step(1'b1, 1'b1, 1'b0, 6'b000001, 3'b000, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000001, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000001, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000001, 3'b011, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000001, 3'b101, 1'b1, 1'b0);

      // LW with a two-cycle memory stall
      step(1'b1, 1'b1, 1'b0, 6'b000110, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000110, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000110, 3'b011, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 6'b000110, 3'b100, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 6'b000110, 3'b100, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000110, 3'b100, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000110, 3'b101, 1'b1, 1'b0);

      // BEQ then PUSH; op changes during BEQ execute must not reroute it
      step(1'b1, 1'b1, 1'b0, 6'b001010, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b001010, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b001111, 3'b011, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b001111, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b001111, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b001111, 3'b100, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b001111, 3'b101, 1'b1, 1'b0);

      // illegal opcode, first stalled in decode (no pulse), then released
      step(1'b1, 1'b1, 1'b0, 6'b111111, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 6'b111111, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b111111, 3'b010, 1'b0, 1'b1);

      // jump retires in decode
      step(1'b1, 1'b1, 1'b0, 6'b001100, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b001100, 3'b010, 1'b1, 1'b0);

      // POP path
      step(1'b1, 1'b1, 1'b0, 6'b010000, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b010000, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b010000, 3'b100, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b010000, 3'b101, 1'b1, 1'b0);

      // SW with run dropped in execute: finishes, then idles
      step(1'b1, 1'b1, 1'b0, 6'b000111, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000111, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 6'b000111, 3'b011, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 6'b000111, 3'b100, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 6'b000111, 3'b000, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 6'b000111, 3'b000, 1'b0, 1'b0);

      // reset while stalled in memory
      step(1'b1, 1'b1, 1'b0, 6'b000110, 3'b000, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000110, 3'b001, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000110, 3'b010, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 6'b000110, 3'b011, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 6'b000110, 3'b100, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 6'b000001, 3'b000, 1'b0, 1'b0);
`ifdef STAGE_SEQ_PERF_EN
      checkEq("count_after_rst", busIf.instr_count, 16'd0);
`endif

      // three back-to-back ADDs
      step(1'b1, 1'b1, 1'b0, 6'b000001, 3'b000, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b1, 1'b0, 6'b000001, 3'b001, 1'b0, 1'b0);
         step(1'b1, 1'b1, 1'b0, 6'b000001, 3'b010, 1'b0, 1'b0);
         step(1'b1, 1'b1, 1'b0, 6'b000001, 3'b011, 1'b0, 1'b0);
         step(1'b1, (k != 2), 1'b0, 6'b000001, 3'b101, 1'b1, 1'b0);
      end
      step(1'b1, 1'b0, 1'b0, 6'b000001, 3'b000, 1'b0, 1'b0);
`ifdef STAGE_SEQ_PERF_EN
      checkEq("count_three", busIf.instr_count, 16'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checkCnt, failCnt);
      $finish;
   end

endmodule
